// File: rtl/accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : accum_pkg
//  Brief    : Shared constants and state encoding for the accumulator
//             read-out (drain) engine.
//  Revision : 1.0 - initial release
// ============================================================================
package accum_pkg;

    // Read port of the accumulator RAM returns data this many cycles after
    // the address is presented.
    localparam int RAM_READ_LATENCY = 2;

    // Output buffer depth; also the credit limit for outstanding reads.
    localparam int DRAIN_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/accum_drain_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : drain_fifo
//  Brief    : Small shift-style synchronous FIFO. Entry 0 is always the head,
//             so the head is a flop. Exposes occupancy for credit tracking.
//  Revision : 1.0 - initial release
// ============================================================================
module drain_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] w_mem_nxt [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [CNT_W-1:0]  w_wr_idx;
    logic              w_pop;
    logic              w_push;

    // A pop frees a slot in the same cycle, so push-while-full is allowed
    // when a pop accompanies it.
    assign w_pop       = i_pop && (r_count != '0);
    assign w_push      = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);
    assign w_wr_idx    = w_pop ? (r_count - CNT_W'(1)) : r_count;
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Next storage contents: shift toward the head on pop, then drop the
    // incoming word into the first free slot.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            w_mem_nxt[i] = w_pop ? r_mem[i+1] : r_mem[i];
        end
        w_mem_nxt[DEPTH-1] = r_mem[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (w_wr_idx == CNT_W'(i))) begin
                w_mem_nxt[i] = i_push_data;
            end
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_count <= w_count_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= w_mem_nxt[i];
            end
        end
    end

    assign o_head  = r_mem[0];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/accum_drain.sv
`default_nettype none
// ============================================================================
//  Module   : accum_drain
//  Brief    : Sweeps the accumulator RAM from address 0 to DEPTH-1, streams
//             each word out on valid/ready with its address and a last flag,
//             and optionally zeroes each location once it has been read.
//  Revision : 1.0 - initial release
// ============================================================================
module accum_drain
    import accum_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int CLEAR = 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     start_in,
    output logic                     busy_out,
    output logic                     done_out,
    output logic [$clog2(DEPTH)-1:0] ram_addr_out,
    input  logic [WIDTH-1:0]         ram_data_in,
    output logic [$clog2(DEPTH)-1:0] ram_waddr_out,
    output logic [WIDTH-1:0]         ram_wdata_out,
    output logic                     ram_we_out,
    output logic [WIDTH-1:0]         data_out,
    output logic [$clog2(DEPTH)-1:0] addr_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic                     last_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int L  = RAM_READ_LATENCY;
    localparam int CW = $clog2(DRAIN_FIFO_DEPTH + 1);
    localparam int OW = $clog2(RAM_READ_LATENCY + DRAIN_FIFO_DEPTH + 1);
    localparam logic [AW-1:0] C_LAST_ADDR = AW'(DEPTH - 1);

    drain_state_t      r_state;
    drain_state_t      w_state_nxt;
    logic [AW-1:0]     r_rd_addr;
    logic [L-1:0]      r_pipe_vld;
    logic [AW-1:0]     r_pipe_addr [L];
    logic [CW-1:0]     w_fifo_count;
    logic [OW-1:0]     w_inflight;
    logic [OW-1:0]     w_outstanding;
    logic              w_issue;
    logic              w_capture;
    logic              w_pop;
    logic              w_fifo_valid;
    logic [WIDTH+AW-1:0] w_head;

    // Count reads still travelling through the RAM latency pipe.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < L; i++) begin
            w_inflight = w_inflight + OW'(r_pipe_vld[i]);
        end
    end

    // Every outstanding read already owns a FIFO slot, so the FIFO can
    // never overflow regardless of back-pressure.
    assign w_outstanding = w_inflight + OW'(w_fifo_count);
    assign w_issue       = (r_state == ISSUE) && (w_outstanding < OW'(DRAIN_FIFO_DEPTH));
    assign w_capture     = r_pipe_vld[L-1];
    assign w_pop         = w_fifo_valid && ready_in;

    // Next-state logic; DONE is entered on the final handshake so the done
    // pulse lands exactly one cycle after it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start_in) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (w_issue && (r_rd_addr == C_LAST_ADDR)) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if ((r_pipe_vld == '0) &&
                    ((w_fifo_count == '0) || ((w_fifo_count == CW'(1)) && w_pop))) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read address advances only when a read is actually issued; it wraps
    // to zero after the last address so the next sweep starts cleanly.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rd_addr <= '0;
        end else if ((r_state == IDLE) && start_in) begin
            r_rd_addr <= '0;
        end else if (w_issue) begin
            r_rd_addr <= (r_rd_addr == C_LAST_ADDR) ? '0 : (r_rd_addr + AW'(1));
        end
    end

    // In-flight pipe: tags each issued read with its address so data and
    // address reach the FIFO together.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < L; i++) begin
                r_pipe_addr[i] <= '0;
            end
        end else begin
            r_pipe_vld     <= {r_pipe_vld[L-2:0], w_issue};
            r_pipe_addr[0] <= r_rd_addr;
            for (int i = 1; i < L; i++) begin
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end
        end
    end

    drain_fifo #(
        .DATA_W (WIDTH + AW),
        .DEPTH  (DRAIN_FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk_in),
        .rst         (rst_in),
        .i_push      (w_capture),
        .i_push_data ({ram_data_in, r_pipe_addr[L-1]}),
        .i_pop       (ready_in),
        .o_head      (w_head),
        .o_valid     (w_fifo_valid),
        .o_count     (w_fifo_count)
    );

    assign ram_addr_out  = r_rd_addr;
    // The read of this location completed this cycle, so zeroing it now
    // cannot disturb the word being captured.
    assign ram_we_out    = (CLEAR != 0) && w_capture;
    assign ram_waddr_out = r_pipe_addr[L-1];
    assign ram_wdata_out = '0;

    assign {data_out, addr_out} = w_head;
    assign valid_out = w_fifo_valid;
    assign last_out  = w_fifo_valid && (addr_out == C_LAST_ADDR);
    assign busy_out  = (r_state != IDLE);
    assign done_out  = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_accum_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_accum_drain
//  Brief    : Self-checking bench for accum_drain (DEPTH=8), one clearing and
//             one read-only instance, each with a 2-cycle-latency RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_accum_drain;

    localparam int W = 16;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready = 1'b0;
    logic start_c = 1'b0;
    logic start_ro = 1'b0;
    logic load_c = 1'b0;
    logic load_ro = 1'b0;
    bit   sel_ro = 1'b0;

    logic [W-1:0] load_vals [D];
    logic [W-1:0] model_c   [D];
    logic [W-1:0] model_ro  [D];

    int vectors = 0;
    int miscompares = 0;

    // Clearing instance signals
    logic         c_busy, c_done, c_we, c_valid, c_last;
    logic [2:0]   c_raddr, c_waddr, c_addr;
    logic [W-1:0] c_rdata, c_wdata, c_data;
    // Read-only instance signals
    logic         ro_busy, ro_done, ro_we, ro_valid, ro_last;
    logic [2:0]   ro_raddr, ro_waddr, ro_addr;
    logic [W-1:0] ro_rdata, ro_wdata, ro_data;

    always #5 clk = ~clk;

    accum_drain #(.WIDTH(W), .DEPTH(D), .CLEAR(1)) u_dut (
        .clk_in(clk), .rst_in(rst), .start_in(start_c), .busy_out(c_busy),
        .done_out(c_done), .ram_addr_out(c_raddr), .ram_data_in(c_rdata),
        .ram_waddr_out(c_waddr), .ram_wdata_out(c_wdata), .ram_we_out(c_we),
        .data_out(c_data), .addr_out(c_addr), .valid_out(c_valid),
        .ready_in(ready), .last_out(c_last)
    );

    accum_drain #(.WIDTH(W), .DEPTH(D), .CLEAR(0)) u_dut_ro (
        .clk_in(clk), .rst_in(rst), .start_in(start_ro), .busy_out(ro_busy),
        .done_out(ro_done), .ram_addr_out(ro_raddr), .ram_data_in(ro_rdata),
        .ram_waddr_out(ro_waddr), .ram_wdata_out(ro_wdata), .ram_we_out(ro_we),
        .data_out(ro_data), .addr_out(ro_addr), .valid_out(ro_valid),
        .ready_in(ready), .last_out(ro_last)
    );

    // RAM models: two registered read stages, write port for clears.
    logic [W-1:0] mem_c [D];
    logic [W-1:0] mem_ro [D];
    logic [W-1:0] c_p1, ro_p1;

    always @(posedge clk) begin
        c_p1    <= mem_c[c_raddr];
        c_rdata <= c_p1;
        if (load_c) begin
            for (int i = 0; i < D; i++) mem_c[i] <= load_vals[i];
        end else if (c_we) begin
            mem_c[c_waddr] <= c_wdata;
        end
    end

    always @(posedge clk) begin
        ro_p1    <= mem_ro[ro_raddr];
        ro_rdata <= ro_p1;
        if (load_ro) begin
            for (int i = 0; i < D; i++) mem_ro[i] <= load_vals[i];
        end else if (ro_we) begin
            mem_ro[ro_waddr] <= ro_wdata;
        end
    end

    // View of whichever instance is under test.
    logic         m_busy, m_done, m_we, m_valid, m_last;
    logic [2:0]   m_raddr, m_waddr, m_addr;
    logic [W-1:0] m_wdata, m_data;
    assign m_busy  = sel_ro ? ro_busy  : c_busy;
    assign m_done  = sel_ro ? ro_done  : c_done;
    assign m_we    = sel_ro ? ro_we    : c_we;
    assign m_valid = sel_ro ? ro_valid : c_valid;
    assign m_last  = sel_ro ? ro_last  : c_last;
    assign m_raddr = sel_ro ? ro_raddr : c_raddr;
    assign m_waddr = sel_ro ? ro_waddr : c_waddr;
    assign m_addr  = sel_ro ? ro_addr  : c_addr;
    assign m_wdata = sel_ro ? ro_wdata : c_wdata;
    assign m_data  = sel_ro ? ro_data  : c_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  m_busy,  0);
        chk({tag, "_done"},  m_done,  0);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_last"},  m_last,  0);
        chk({tag, "_we"},    m_we,    0);
        chk({tag, "_raddr"}, m_raddr, 0);
        chk({tag, "_waddr"}, m_waddr, 0);
        chk({tag, "_addr"},  m_addr,  0);
        chk({tag, "_data"},  m_data,  0);
        chk({tag, "_wdata"}, m_wdata, 0);
    endtask

    task automatic set_start(input bit ro, input logic v);
        if (ro) start_ro = v; else start_c = v;
    endtask

    // Fill a RAM with 10*i or random words; the model follows.
    task automatic preload(input bit ro, input bit rnd);
        for (int i = 0; i < D; i++) begin
            load_vals[i] = rnd ? W'($urandom_range(0, 65535)) : W'(10 * i);
            if (ro) model_ro[i] = load_vals[i]; else model_c[i] = load_vals[i];
        end
        if (ro) load_ro = 1'b1; else load_c = 1'b1;
        @(negedge clk);
        load_c  = 1'b0;
        load_ro = 1'b0;
    endtask

    task automatic chk_ram(input bit ro);
        for (int i = 0; i < D; i++) begin
            if (ro) chk("ram_contents", mem_ro[i], model_ro[i]);
            else    chk("ram_contents", mem_c[i],  model_c[i]);
        end
    endtask

    // One sweep from a negedge. Expected beats come from the content model;
    // after a full clearing sweep the model is all zeros.
    task automatic sweep(input bit ro, input bit rnd, input bit timed,
                         input bit extra_starts, input bit stall_end, input int rst_at);
        logic [W-1:0] exp_d [D];
        int idx, clr_idx, cyc, accept_cyc, stall_left;
        bit prev_hold, last_seen, finished;
        logic [W-1:0] pd;
        logic [2:0] pa;
        logic pl;
        idx = 0; clr_idx = 0; accept_cyc = -10; stall_left = 0;
        prev_hold = 0; last_seen = 0; finished = 0; pd = '0; pa = '0; pl = 1'b0;
        for (int i = 0; i < D; i++) exp_d[i] = ro ? model_ro[i] : model_c[i];
        sel_ro = ro;
        ready = 1'b1;
        set_start(ro, 1'b1);
        @(negedge clk);
        set_start(ro, 1'b0);
        cyc = 1;
        while (cyc < 200) begin
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                chk_reset_vals("midreset");
                for (int k = 0; k < D; k++) if (3 + k < rst_at) model_c[k] = '0;
                @(negedge clk);
                rst = 1'b0;
                chk_ram(ro);
                return;
            end
            if (prev_hold) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data",  m_data,  pd);
                chk("hold_addr",  m_addr,  pa);
                chk("hold_last",  m_last,  pl);
            end
            if (m_valid) begin
                chk("beat_addr", m_addr, idx);
                chk("beat_data", m_data, exp_d[idx[2:0]]);
                chk("beat_last", m_last, (idx == D - 1));
            end else begin
                chk("last_without_valid", m_last, 0);
            end
            if (timed) begin
                chk("t_valid", m_valid, (cyc >= 4 && cyc <= 11));
                chk("t_we",    m_we,    (cyc >= 3 && cyc <= 10));
                if (cyc <= 8) chk("t_raddr", m_raddr, cyc - 1);
                if (m_valid) chk("t_beat_cycle", idx, cyc - 4);
            end
            chk("done", m_done, (cyc == accept_cyc + 1));
            chk("busy", m_busy, (accept_cyc < 0 || cyc <= accept_cyc + 1));
            if (ro) chk("ro_we", m_we, 0);
            else if (m_we) begin
                chk("clear_order", m_waddr, clr_idx);
                chk("clear_data",  m_wdata, 0);
                clr_idx++;
            end
            chk("issue_ahead", (int'(m_raddr) <= idx + 4), 1);
            if (cyc == accept_cyc + 1) begin
                finished = 1;
                if (extra_starts) set_start(ro, 1'b1);
                break;
            end
            if (stall_end && m_last && !last_seen) stall_left = 5;
            if (m_last) last_seen = 1;
            if (stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
            end else begin
                ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            set_start(ro, extra_starts && (cyc == 2 || cyc == 6));
            if (m_valid && ready) begin
                if (idx == D - 1) accept_cyc = cyc;
                idx++;
                prev_hold = 0;
            end else begin
                prev_hold = m_valid;
                pd = m_data; pa = m_addr; pl = m_last;
            end
            @(negedge clk);
            cyc++;
        end
        chk("sweep_done_seen", finished, 1);
        chk("beat_count", idx, D);
        chk("clear_count", clr_idx, ro ? 0 : D);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            set_start(ro, 1'b0);
            chk("tail_busy",  m_busy,  0);
            chk("tail_done",  m_done,  0);
            chk("tail_valid", m_valid, 0);
        end
        if (!ro) for (int i = 0; i < D; i++) model_c[i] = '0;
        chk_ram(ro);
    endtask

    initial begin
        // Reset state of both instances.
        @(negedge clk);
        @(negedge clk);
        sel_ro = 0; chk_reset_vals("reset_c");
        sel_ro = 1; chk_reset_vals("reset_ro");
        rst = 1'b0;
        @(negedge clk);

        // Basic sweep with exact timing, then a sweep of the cleared RAM.
        preload(0, 0);
        sweep(0, 0, 1, 0, 0, -1);
        sweep(0, 0, 1, 0, 0, -1);

        // Back-pressure with random ready and random contents.
        preload(0, 1);
        sweep(0, 1, 0, 0, 0, -1);
        preload(0, 0);
        sweep(0, 1, 0, 0, 0, -1);

        // Read-only sweeps return identical data twice.
        preload(1, 0);
        sweep(1, 0, 0, 0, 0, -1);
        sweep(1, 1, 0, 0, 0, -1);

        // Start pulses while busy and in DONE are ignored.
        preload(0, 0);
        sweep(0, 0, 0, 1, 0, -1);

        // Stall on the last beat.
        preload(0, 1);
        sweep(0, 0, 0, 0, 1, -1);

        // Reset before the third clear lands; then a full recovery sweep.
        preload(0, 0);
        sweep(0, 0, 0, 0, 0, 5);
        sweep(0, 0, 0, 0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
